br_bias_loader: RTL and testbench

BR_BIAS_LOADER -- requirements
Module: br_bias_loader

---
 rtl/br_pkg.sv | 29 ++
 rtl/br_bias_buf.sv | 44 ++++
 rtl/br_bias_loader.sv | 146 ++++++++++++++
 tb/tb_br_bias_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : br_pkg
//  Description : Shared types and constants for the bias loader: word and
//                address widths, default load size and timeout, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package br_pkg;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 8;
    localparam int N_BIAS_DEF  = 256;
    localparam int TIMEOUT_DEF = 1023;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_REL  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } br_state_t;

    // Bits needed to count up to t (at least one bit).
    function automatic int wait_width(input int t);
        return (t < 2) ? 1 : $clog2(t + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/br_bias_buf.sv
`default_nettype none
// ============================================================================
//  Module      : br_bias_buf
//  Description : 256x8 bias word buffer. One synchronous write port, one
//                registered read port with read-before-write behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module br_bias_buf
    import br_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int c_depth = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];
    logic [DATA_W-1:0] r_rdata;

    // Storage array: contents survive reset so a partial load stays readable.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; a write to the same address this cycle returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/br_bias_loader.sv
`default_nettype none
// ============================================================================
//  Module      : br_bias_loader
//  Description : Fetches N_BIAS bias bytes from an external memory through a
//                four-phase readM/ready handshake into a local buffer, with a
//                per-edge timeout and a registered buffer read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module br_bias_loader
    import br_pkg::*;
#(
    parameter int N_BIAS  = N_BIAS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              readM,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int                WAIT_W      = wait_width(TIMEOUT);
    localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(N_BIAS - 1);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);

    br_state_t         r_state;
    br_state_t         w_state_nxt;
    logic              r_ready_m;
    logic              r_ready_s;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [WAIT_W-1:0] r_wcnt;
    logic [WAIT_W-1:0] w_wcnt_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              w_we;

    // Two-flop synchronizer: ready comes from another clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready_m <= 1'b0;
            r_ready_s <= 1'b0;
        end else begin
            r_ready_m <= ready;
            r_ready_s <= r_ready_m;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Index, wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_wcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_wcnt <= w_wcnt_nxt;
            r_err  <= w_err_nxt;
        end
    end

    // Next-state, datapath updates and buffer write strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wcnt_nxt  = r_wcnt;
        w_err_nxt   = r_err;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_REQ;
                    w_idx_nxt   = '0;
                    w_wcnt_nxt  = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            ST_REQ: begin
                if (r_ready_s) begin
                    // First cycle ready_s is seen high: capture the byte once.
                    w_we        = 1'b1;
                    w_state_nxt = ST_REL;
                    w_wcnt_nxt  = '0;
                end else if (r_wcnt == c_wait_last) begin
                    w_state_nxt = ST_ERR;
                    w_wcnt_nxt  = '0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt + WAIT_W'(1);
                end
            end
            ST_REL: begin
                if (!r_ready_s) begin
                    w_wcnt_nxt = '0;
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + ADDR_W'(1);
                        w_state_nxt = ST_REQ;
                    end
                end else if (r_wcnt == c_wait_last) begin
                    w_state_nxt = ST_ERR;
                    w_wcnt_nxt  = '0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt + WAIT_W'(1);
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign readM = (r_state == ST_REQ);
    assign busy  = (r_state == ST_REQ) || (r_state == ST_REL);
    assign done  = (r_state == ST_DONE);
    assign err   = r_err;

    br_bias_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (data),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_br_bias_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_br_bias_loader
//  Description : Directed self-checking bench. Instance A: 16 words, short
//                timeout. Instance B: default 256 words. A behavioural bias
//                memory answers each readM with ready after a fixed latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_br_bias_loader;

    localparam int TO_A = 40;
    localparam int LAT  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_v;
    logic [1:0] readM_v;
    logic [1:0] ready_v;
    logic [1:0] busy_v;
    logic [1:0] done_v;
    logic [1:0] err_v;
    logic [7:0] data_v    [2];
    logic [7:0] rd_addr_v [2];
    logic [7:0] rd_data_v [2];

    int cnt [2];
    int base [2];
    int stall [2];
    int mode [2];
    int lat [2];
    int done_cnt [2];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    br_bias_loader #(.N_BIAS(16), .TIMEOUT(TO_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .readM(readM_v[0]),
        .ready(ready_v[0]), .data(data_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .err(err_v[0]), .rd_addr(rd_addr_v[0]), .rd_data(rd_data_v[0])
    );

    br_bias_loader u_dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .readM(readM_v[1]),
        .ready(ready_v[1]), .data(data_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .err(err_v[1]), .rd_addr(rd_addr_v[1]), .rd_data(rd_data_v[1])
    );

    function automatic logic [7:0] pat(input int m, input int a);
        logic [7:0] b;
        b = a[7:0];
        case (m)
            0:       return 8'h80;
            1:       return b;
            2:       return ~b;
            default: return b ^ 8'h5A;
        endcase
    endfunction

    // Bias memory model: ready follows readM after LAT cycles, word address
    // is the number of completed handshakes since the bench's base mark.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ready_v[i] = 1'b0;
                data_v[i]  = 8'h00;
                cnt[i]     = 0;
                lat[i]     = 0;
            end else if (readM_v[i] && !ready_v[i]) begin
                if ((cnt[i] - base[i]) == stall[i]) begin
                    lat[i] = 0;
                end else if (lat[i] >= LAT) begin
                    data_v[i]  = pat(mode[i], cnt[i] - base[i]);
                    ready_v[i] = 1'b1;
                    lat[i]     = 0;
                end else begin
                    lat[i]++;
                end
            end else if (!readM_v[i] && ready_v[i]) begin
                if (lat[i] >= LAT) begin
                    ready_v[i] = 1'b0;
                    cnt[i]++;
                    lat[i] = 0;
                end else begin
                    lat[i]++;
                end
            end else begin
                lat[i] = 0;
            end
            if (done_v[i]) done_cnt[i]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input int i, input int a, input logic [7:0] exp, input string tag);
        rd_addr_v[i] = a[7:0];
        @(negedge clk);
        chk(tag, {24'h0, rd_data_v[i]}, {24'h0, exp});
    endtask

    task automatic pulse_start(input int i);
        base[i]    = cnt[i];
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int maxc, input string tag);
        int n;
        n = 0;
        while (!done_v[i] && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done_v[i]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        logic found;
        rst          = 1'b1;
        start_v      = 2'b00;
        rd_addr_v[0] = 8'h00;
        rd_addr_v[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            stall[i] = -1;
            mode[i]  = 0;
            base[i]  = 0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_readM", 32'(readM_v), 32'd0);
        chk("rst_busy",  32'(busy_v),  32'd0);
        chk("rst_done",  32'(done_v),  32'd0);
        chk("rst_err",   32'(err_v),   32'd0);
        chk("rst_rdata_a", 32'(rd_data_v[0]), 32'd0);
        chk("rst_rdata_b", 32'(rd_data_v[1]), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full 256-word load of constant 0x80
        pulse_start(1);
        chk("b_readM_rise", 32'(readM_v[1]), 32'd1);
        chk("b_busy", 32'(busy_v[1]), 32'd1);
        wait_done(1, 6000, "b_done");
        chk("b_words", cnt[1] - base[1], 32'd256);
        chk("b_readM_in_done", 32'(readM_v[1]), 32'd0);
        @(negedge clk);
        chk("b_done_one_cycle", 32'(done_v[1]), 32'd0);
        rd_chk(1, 0,   8'h80, "b_buf0");
        rd_chk(1, 127, 8'h80, "b_buf127");
        rd_chk(1, 255, 8'h80, "b_buf255");
        chk("b_done_count", done_cnt[1], 32'd1);

        // 16-word load of address bytes
        mode[0] = 1;
        d0      = done_cnt[0];
        pulse_start(0);
        chk("a_readM_rise", 32'(readM_v[0]), 32'd1);
        wait_done(0, 1000, "a_done");
        chk("a_words", cnt[0] - base[0], 32'd16);
        chk("a_readM_in_done", 32'(readM_v[0]), 32'd0);
        chk("a_busy_in_done", 32'(busy_v[0]), 32'd0);
        chk("a_err", 32'(err_v[0]), 32'd0);
        for (int k = 0; k < 16; k++) rd_chk(0, k, 8'(k), $sformatf("a_buf[%0d]", k));
        chk("a_done_count", done_cnt[0] - d0, 32'd1);

        // Repeated start during busy must be ignored
        mode[0] = 2;
        d0      = done_cnt[0];
        pulse_start(0);
        for (int k = 0; k < 2000 && !done_v[0]; k++) begin
            start_v[0] = busy_v[0] && (k % 3 == 0);
            @(negedge clk);
        end
        start_v[0] = 1'b0;
        chk("rep_done", 32'(done_v[0]), 32'd1);
        chk("rep_words", cnt[0] - base[0], 32'd16);
        repeat (3) @(negedge clk);
        chk("rep_done_count", done_cnt[0] - d0, 32'd1);
        chk("rep_err", 32'(err_v[0]), 32'd0);
        chk("rep_idle", 32'(busy_v[0]), 32'd0);
        for (int k = 0; k < 16; k++) rd_chk(0, k, ~8'(k), $sformatf("rep_buf[%0d]", k));

        // Memory stalls at word 5: timeout
        mode[0]  = 1;
        stall[0] = 5;
        d0       = done_cnt[0];
        pulse_start(0);
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            if (readM_v[0] && (cnt[0] - base[0]) == 5) found = 1'b1;
            else @(negedge clk);
        end
        chk("to_reach_word5", 32'(found), 32'd1);
        n = 0;
        while (!err_v[0] && n < TO_A + 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, TO_A);
        chk("to_readM", 32'(readM_v[0]), 32'd0);
        repeat (2) @(negedge clk);
        chk("to_idle", 32'(busy_v[0]), 32'd0);
        chk("to_err_sticky", 32'(err_v[0]), 32'd1);
        chk("to_no_done", done_cnt[0] - d0, 32'd0);
        stall[0] = -1;
        for (int k = 0; k < 5; k++) rd_chk(0, k, 8'(k), $sformatf("to_buf[%0d]", k));
        rd_chk(0, 5, 8'hFA, "to_buf5_kept");
        chk("to_err_still", 32'(err_v[0]), 32'd1);

        // Reset during REL of word 10, then reload
        mode[0] = 3;
        d0      = done_cnt[0];
        pulse_start(0);
        chk("ab_err_cleared", 32'(err_v[0]), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            if (!readM_v[0] && busy_v[0] && ready_v[0] && (cnt[0] - base[0]) == 10) found = 1'b1;
            else @(negedge clk);
        end
        chk("ab_reach_rel10", 32'(found), 32'd1);
        rst        = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        chk("ab_readM", 32'(readM_v[0]), 32'd0);
        chk("ab_busy",  32'(busy_v[0]),  32'd0);
        chk("ab_done",  32'(done_v[0]),  32'd0);
        chk("ab_rdata", 32'(rd_data_v[0]), 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("ab_rst_beats_start", 32'(busy_v[0]), 32'd0);
        chk("ab_no_done", done_cnt[0] - d0, 32'd0);
        pulse_start(0);
        wait_done(0, 1000, "ab_reload_done");
        chk("ab_reload_words", cnt[0] - base[0], 32'd16);
        rd_chk(0, 0,  8'h5A, "ab_buf0");
        rd_chk(0, 10, 8'h50, "ab_buf10");
        rd_chk(0, 15, 8'h55, "ab_buf15");
        chk("ab_done_count", done_cnt[0] - d0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
